demux_8_buf: RTL and testbench

DEMUX_8_BUF -- requirements
Module: demux_8_buf

---
 rtl/demux_8_buf_pkg.sv | 23 ++
 rtl/demux_8_buf_slot.sv | 51 +++++
 rtl/demux_8_buf.sv | 88 ++++++++
 tb/tb_demux_8_buf.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/demux_8_buf_pkg.sv
// Shared constants, slot state encoding and helpers for the 8-slot buffered demux.
package demux_8_buf_pkg;

  localparam int SLOTS = 8;
  localparam int SEL_W = 3;
  localparam int OCC_W = 4;
  localparam int CNT_W = 8;

  // Per-slot state: a slot either holds an unconsumed word or it does not.
  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  // One-hot decode of a slot index.
  function automatic logic [SLOTS-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
    logic [SLOTS-1:0] onehot;
    onehot = '0;
    onehot[sel] = 1'b1;
    return onehot;
  endfunction

endpackage

// File: rtl/demux_8_buf_slot.sv
// Single output slot: data register plus EMPTY/FULL state with load and ack handling.
module demux_slot
  import demux_8_buf_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic             ack,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] data,
  output logic             valid
);

  slot_state_e      state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;

  // State and data registers; reset discards any held word.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  // Next state: a load always leaves the slot FULL (a same-cycle ack consumes the old
  // word); an ack alone empties it. Data persists after consumption until reloaded.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    case (state_q)
      SLOT_EMPTY: begin
        if (load) state_d = SLOT_FULL;
      end
      SLOT_FULL: begin
        if (load)     state_d = SLOT_FULL;
        else if (ack) state_d = SLOT_EMPTY;
      end
      default: state_d = SLOT_EMPTY;
    endcase
    if (load) data_d = in_data;
  end

  assign data  = data_q;
  assign valid = (state_q == SLOT_FULL);

endmodule

// File: rtl/demux_8_buf.sv
// 8-way demultiplexer with one buffered word per output slot, occupancy and overflow counters.
module demux_8_buf
  import demux_8_buf_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SEL_W-1:0]       select,
  input  logic [WIDTH-1:0]       in_data,
  output logic [SLOTS*WIDTH-1:0] out_data,
  output logic [SLOTS-1:0]       out_valid,
  input  logic [SLOTS-1:0]       out_ack,
  output logic [OCC_W-1:0]       occupancy,
  output logic [CNT_W-1:0]       overflow_cnt
);

  logic             transfer;
  logic             stall;
  logic [SLOTS-1:0] load_vec;
  logic [OCC_W-1:0] occupancy_q, occupancy_d;
  logic [CNT_W-1:0] overflow_q, overflow_d;

  // The selected slot can take a word if it is empty or being drained this cycle.
  // During reset nothing is held, so the block advertises ready.
  assign in_ready = !reset_n || !out_valid[select] || out_ack[select];
  assign transfer = in_valid && in_ready;
  assign stall    = in_valid && !in_ready;

  // Route the load strobe to the selected slot only on a transfer.
  always_comb begin
    load_vec = '0;
    if (transfer) load_vec = sel_onehot(select);
  end

  generate
    for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
      demux_slot #(
        .WIDTH(WIDTH)
      ) u_slot (
        .clock   (clock),
        .reset_n (reset_n),
        .load    (load_vec[gi]),
        .ack     (out_ack[gi]),
        .in_data (in_data),
        .data    (out_data[gi*WIDTH +: WIDTH]),
        .valid   (out_valid[gi])
      );
    end
  endgenerate

  // Occupancy delta: +1 for a load into an empty slot, -1 for each ack of a
  // full slot that is not refilled in the same cycle.
  always_comb begin
    logic [OCC_W-1:0] inc_cnt;
    logic [OCC_W-1:0] dec_cnt;
    inc_cnt = '0;
    dec_cnt = '0;
    if (transfer && !out_valid[select]) inc_cnt = OCC_W'(1);
    for (int k = 0; k < SLOTS; k++) begin
      if (out_ack[k] && out_valid[k] && !load_vec[k]) dec_cnt = dec_cnt + OCC_W'(1);
    end
    occupancy_d = occupancy_q + inc_cnt - dec_cnt;
  end

  // Overflow counter counts stalled offer cycles and sticks at its maximum.
  always_comb begin
    overflow_d = overflow_q;
    if (stall && (overflow_q != {CNT_W{1'b1}})) overflow_d = overflow_q + CNT_W'(1);
  end

  // Counter registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      occupancy_q <= '0;
      overflow_q  <= '0;
    end else begin
      occupancy_q <= occupancy_d;
      overflow_q  <= overflow_d;
    end
  end

  assign occupancy    = occupancy_q;
  assign overflow_cnt = overflow_q;

endmodule

// File: tb/tb_demux_8_buf.sv
// Self-checking bench for demux_8_buf: directed scenarios followed by random traffic,
// compared against a slot-array reference model.
module tb_demux_8_buf;

  localparam int W = 32;

  logic           clock;
  logic           reset_n;
  logic           in_valid;
  logic           in_ready;
  logic [2:0]     select;
  logic [W-1:0]   in_data;
  logic [8*W-1:0] out_data;
  logic [7:0]     out_valid;
  logic [7:0]     out_ack;
  logic [3:0]     occupancy;
  logic [7:0]     overflow_cnt;

  demux_8_buf #(.WIDTH(W)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .select       (select),
    .in_data      (in_data),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ack      (out_ack),
    .occupancy    (occupancy),
    .overflow_cnt (overflow_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model state
  bit       m_full [8];
  bit [31:0] m_word [8];
  int       m_ovf;

  int n_checks = 0;
  int n_errors = 0;
  bit last_stall = 0;

  task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 8; k++) begin
      m_full[k] = 0;
      m_word[k] = '0;
    end
    m_ovf = 0;
  endtask

  task automatic compare_outputs();
    logic [7:0]   ev;
    logic [255:0] ed;
    int           cnt;
    ev  = '0;
    ed  = '0;
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      ev[k] = m_full[k];
      ed[k*32 +: 32] = m_word[k];
      if (m_full[k]) cnt++;
    end
    check_val("out_valid", out_valid, ev);
    check_val("out_data", out_data, ed);
    check_val("occupancy", occupancy, cnt[3:0]);
    check_val("overflow_cnt", overflow_cnt, m_ovf[7:0]);
  endtask

  // One clock of traffic: drive after the falling edge, check ready, advance
  // the model at the rising edge, check registered outputs at the next falling edge.
  task automatic drive_cycle(input logic iv, input logic [2:0] s, input logic [31:0] d,
                             input logic [7:0] a);
    bit rdy;
    in_valid = iv;
    select   = s;
    in_data  = d;
    out_ack  = a;
    #1;
    rdy = !m_full[s] || a[s];
    check_val("in_ready", in_ready, rdy);
    last_stall = iv && !rdy;
    @(posedge clock);
    for (int k = 0; k < 8; k++) begin
      if (iv && rdy && (int'(s) == k)) begin
        m_full[k] = 1;
        m_word[k] = d;
      end else if (a[k]) begin
        m_full[k] = 0;
      end
    end
    if (iv && !rdy && m_ovf < 255) m_ovf++;
    @(negedge clock);
    compare_outputs();
  endtask

  // Asynchronous reset asserted mid-cycle, checked before any clock edge.
  task automatic async_reset();
    #2;
    reset_n = 1'b0;
    #1;
    model_clear();
    check_val("rst_out_valid", out_valid, 8'h00);
    check_val("rst_occupancy", occupancy, 4'd0);
    check_val("rst_overflow", overflow_cnt, 8'd0);
    check_val("rst_out_data", out_data, 256'd0);
    check_val("rst_in_ready", in_ready, 1'b1);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    logic       iv;
    logic [2:0] s;
    logic [31:0] d;
    logic [7:0] a;

    reset_n  = 1'b0;
    in_valid = 1'b1;
    select   = 3'd3;
    in_data  = 32'h1234_5678;
    out_ack  = '0;
    model_clear();
    #3;
    check_val("reset_out_valid", out_valid, 8'h00);
    check_val("reset_in_ready", in_ready, 1'b1);
    compare_outputs();
    @(negedge clock);
    @(negedge clock);
    check_val("reset_no_transfer", out_valid, 8'h00);
    reset_n = 1'b1;

    // First transfer after reset lands in slot 5 with one cycle of latency.
    drive_cycle(1, 3'd5, 32'hDEAD_BEEF, 8'h00);
    check_val("first_valid", out_valid, 8'b0010_0000);
    check_val("first_slot5", out_data[5*32 +: 32], 32'hDEAD_BEEF);
    check_val("first_occ", occupancy, 4'd1);

    // Slot 2 full, three stalled offers.
    drive_cycle(1, 3'd2, 32'h1, 8'h00);
    for (int i = 0; i < 3; i++) drive_cycle(1, 3'd2, 32'hBAD, 8'h00);
    check_val("stall_slot2", out_data[2*32 +: 32], 32'h1);
    check_val("stall_ovf", overflow_cnt, 8'd3);

    // Replace-with-ack keeps slot 2 full with the new word.
    drive_cycle(1, 3'd2, 32'h2, 8'h04);
    check_val("replace_slot2", out_data[2*32 +: 32], 32'h2);
    check_val("replace_valid2", out_valid[2], 1'b1);
    check_val("replace_occ", occupancy, 4'd2);

    // Drain, fill all eight with k, then drain all at once.
    drive_cycle(0, 3'd0, 32'h0, 8'hFF);
    for (int k = 0; k < 8; k++) drive_cycle(1, 3'(k), 32'(k), 8'h00);
    check_val("fill_occ", occupancy, 4'd8);
    drive_cycle(0, 3'd0, 32'h0, 8'hFF);
    check_val("drain_occ", occupancy, 4'd0);
    check_val("drain_valid", out_valid, 8'h00);
    for (int k = 0; k < 8; k++) check_val("drain_keep", out_data[k*32 +: 32], 256'(k));

    // Ack of an empty slot changes nothing.
    drive_cycle(0, 3'd0, 32'h0, 8'h5A);

    // Long stall saturates the overflow counter.
    drive_cycle(1, 3'd0, 32'hA0, 8'h00);
    for (int i = 0; i < 300; i++) drive_cycle(1, 3'd0, 32'hB0, 8'h00);
    check_val("ovf_sat", overflow_cnt, 8'd255);

    // Four slots full, then asynchronous reset mid-cycle.
    for (int k = 1; k < 4; k++) drive_cycle(1, 3'(k), 32'h100 + 32'(k), 8'h00);
    check_val("pre_rst_occ", occupancy, 4'd4);
    async_reset();
    drive_cycle(1, 3'd6, 32'hCAFE_F00D, 8'h00);
    check_val("post_rst_valid", out_valid, 8'b0100_0000);

    // Random traffic; a stalled producer holds its select and data.
    s = 3'd0;
    d = '0;
    for (int i = 0; i < 500; i++) begin
      iv = ($urandom_range(0, 3) != 0);
      if (!last_stall) begin
        s = 3'($urandom_range(0, 7));
        d = $urandom;
      end else begin
        iv = 1'b1;
      end
      a = 8'($urandom & $urandom);
      drive_cycle(iv, s, d, a);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Absolute bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
